// File: rtl/conv_output_streamer_pkg.sv
// Shared definitions for the convolution layer read side.
// Holds the default word width, the state encoding of the streamer, and
// small elaboration-time helpers (clog2, index widths, frame/map sizes) that
// the convolution layer and its loader use as well.
package conv_output_streamer_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width of an index counter over v items; never narrower than one bit.
  function automatic int idx_w(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  // N: words in one frame (all feature maps).
  function automatic int frame_words(input int k, input int oh, input int ow);
    return k * oh * ow;
  endfunction

  // P: words in one feature map.
  function automatic int map_words(input int oh, input int ow);
    return oh * ow;
  endfunction

endpackage

// File: rtl/conv_output_streamer_index.sv
// conv_stream_index: word / pixel / map counters for the output streamer.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   inc         advance one word (a handshake happened)
//   clr         restart at word 0 of a new frame; wins over inc
//   w           word index within the frame (0..N-1)
//   c           feature-map index (0..K-1)
//   ch_last     current word is the last pixel of its map
//   last        current word is the last word of the frame
// The flags are decoded from the registered counters, so they carry no
// combinational dependency on inc.
module conv_stream_index
  import conv_output_streamer_pkg::*;
#(
  parameter int N = 8,
  parameter int P = 4,
  parameter int K = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  output logic [idx_w(N)-1:0] w,
  output logic [idx_w(K)-1:0] c,
  output logic                ch_last,
  output logic                last
);

  localparam int WW = idx_w(N);
  localparam int CW = idx_w(K);
  localparam int PW = idx_w(P);

  localparam logic [WW-1:0] W_LAST = WW'(N - 1);
  localparam logic [CW-1:0] C_LAST = CW'(K - 1);
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);

  logic [PW-1:0] p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w <= '0;
      c <= '0;
      p <= '0;
    end else if (clr) begin
      w <= '0;
      c <= '0;
      p <= '0;
    end else if (inc) begin
      w <= (w == W_LAST) ? '0 : w + 1'b1;
      if (p == P_LAST) begin
        p <= '0;
        c <= (c == C_LAST) ? '0 : c + 1'b1;
      end else begin
        p <= p + 1'b1;
      end
    end
  end

  assign ch_last = (p == P_LAST);
  assign last    = (w == W_LAST);

endmodule

// File: rtl/conv_output_streamer.sv
// conv_output_streamer: snapshots a finished convolution frame and streams it
// one word per cycle over valid/ready, tagged with map index and map/frame
// end markers.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   conv_done    one-cycle pulse, conv_data holds a complete frame
//   conv_data    flat frame, word 0 on the MSB side
//   m_valid/m_ready/m_data   output stream
//   m_ch         feature-map index of the current word
//   m_ch_last    last word of the current map
//   m_last       last word of the frame
//   busy         a frame is held or streaming
//   overrun      sticky: a frame arrived while one could not be accepted
// All outputs come from registered state; m_ready only feeds next-state logic.
module conv_output_streamer
  import conv_output_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int K          = 16,
  parameter int OH         = 10,
  parameter int OW         = 10
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      conv_done,
  input  logic [0:frame_words(K,OH,OW)*DATA_WIDTH-1] conv_data,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic [DATA_WIDTH-1:0]                     m_data,
  output logic [idx_w(K)-1:0]                       m_ch,
  output logic                                      m_ch_last,
  output logic                                      m_last,
  output logic                                      busy,
  output logic                                      overrun
);

  localparam int N  = frame_words(K, OH, OW);
  localparam int P  = map_words(OH, OW);
  localparam int WW = idx_w(N);
  localparam int CW = idx_w(K);

  state_t                state;
  logic [DATA_WIDTH-1:0] frame [N];
  logic [WW-1:0]         w;
  logic [CW-1:0]         c;
  logic                  ch_last;
  logic                  w_last;
  logic                  hs;
  logic                  load;

  assign hs   = (state == STREAM) & m_ready;
  // A new frame is taken when idle, or when it lands exactly on the final
  // handshake of the current frame (gapless back-to-back).
  assign load = conv_done & ((state == IDLE) | (hs & w_last));

  conv_stream_index #(
    .N (N),
    .P (P),
    .K (K)
  ) u_index (
    .clk     (clk),
    .reset   (reset),
    .inc     (hs),
    .clr     (load),
    .w       (w),
    .c       (c),
    .ch_last (ch_last),
    .last    (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (conv_done) state <= STREAM;
        end
        STREAM: begin
          if (conv_done & ~load) overrun <= 1'b1;
          if (hs & w_last & ~conv_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) frame[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < N; i++) frame[i] <= conv_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Outputs are forced to zero outside STREAM so idle and reset read as 0.
  assign m_valid   = (state == STREAM);
  assign busy      = m_valid;
  assign m_data    = m_valid ? frame[w] : '0;
  assign m_ch      = m_valid ? c : '0;
  assign m_ch_last = m_valid & ch_last;
  assign m_last    = m_valid & w_last;

endmodule

// File: tb/tb_conv_output_streamer.sv
// Bench for conv_output_streamer: a small instance (K=2, 2x2 maps, 8-bit)
// for directed scenarios and a default-sized instance for a random frame.
// A queue-based model predicts the stream; a compare process checks every
// cycle, and directed literal checks pin the model.
module tb_conv_output_streamer;

  localparam int NS = 8,    PS = 4,   DS = 8;
  localparam int NL = 1600, PL = 100, DL = 32;

  typedef struct {
    logic [31:0] d;
    int          ch;
    bit          chl;
    bit          lst;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // small instance
  logic              done_s, ready_s;
  logic [DS-1:0]     fw_s [NS];
  logic [0:NS*DS-1]  cd_s;
  logic              m_valid_s, m_ch_last_s, m_last_s, busy_s, ovr_s_dut;
  logic [DS-1:0]     m_data_s;
  logic [0:0]        m_ch_s;

  // default instance
  logic              done_l, ready_l;
  logic [DL-1:0]     fw_l [NL];
  logic [0:NL*DL-1]  cd_l;
  logic              m_valid_l, m_ch_last_l, m_last_l, busy_l, ovr_l_dut;
  logic [DL-1:0]     m_data_l;
  logic [3:0]        m_ch_l;

  always_comb begin
    cd_s = '0;
    for (int i = 0; i < NS; i++) cd_s[i*DS +: DS] = fw_s[i];
  end
  always_comb begin
    cd_l = '0;
    for (int i = 0; i < NL; i++) cd_l[i*DL +: DL] = fw_l[i];
  end

  conv_output_streamer #(.DATA_WIDTH(DS), .K(2), .OH(2), .OW(2)) dut_s (
    .clk(clk), .reset(rst), .conv_done(done_s), .conv_data(cd_s),
    .m_valid(m_valid_s), .m_ready(ready_s), .m_data(m_data_s), .m_ch(m_ch_s),
    .m_ch_last(m_ch_last_s), .m_last(m_last_s), .busy(busy_s), .overrun(ovr_s_dut)
  );

  conv_output_streamer dut_l (
    .clk(clk), .reset(rst), .conv_done(done_l), .conv_data(cd_l),
    .m_valid(m_valid_l), .m_ready(ready_l), .m_data(m_data_l), .m_ch(m_ch_l),
    .m_ch_last(m_ch_last_l), .m_last(m_last_l), .busy(busy_l), .overrun(ovr_l_dut)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending words of the held frame live in a queue; an accepted frame pushes
  // all N words, each handshake pops one.
  ent_t qs[$];
  ent_t ql[$];
  bit   ovr_s, ovr_l;

  always @(posedge clk or posedge rst) begin : mdl
    int bs, bl;
    if (rst) begin
      qs.delete(); ql.delete();
      ovr_s = 0; ovr_l = 0;
    end else begin
      bs = qs.size();
      if (bs > 0 && ready_s) void'(qs.pop_front());
      if (done_s) begin
        if (bs == 0 || (bs == 1 && ready_s)) begin
          for (int i = 0; i < NS; i++)
            qs.push_back('{32'(fw_s[i]), i / PS, (i % PS) == PS - 1, i == NS - 1});
        end else ovr_s = 1;
      end
      bl = ql.size();
      if (bl > 0 && ready_l) void'(ql.pop_front());
      if (done_l) begin
        if (bl == 0 || (bl == 1 && ready_l)) begin
          for (int i = 0; i < NL; i++)
            ql.push_back('{fw_l[i], i / PL, (i % PL) == PL - 1, i == NL - 1});
        end else ovr_l = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("s_valid", m_valid_s, qs.size() > 0);
      chk("s_busy", busy_s, qs.size() > 0);
      chk("s_overrun", ovr_s_dut, ovr_s);
      if (qs.size() > 0) begin
        chk("s_data", m_data_s, qs[0].d);
        chk("s_ch", m_ch_s, qs[0].ch);
        chk("s_ch_last", m_ch_last_s, qs[0].chl);
        chk("s_last", m_last_s, qs[0].lst);
      end
      chk("l_valid", m_valid_l, ql.size() > 0);
      chk("l_busy", busy_l, ql.size() > 0);
      chk("l_overrun", ovr_l_dut, ovr_l);
      if (ql.size() > 0) begin
        chk("l_data", m_data_l, ql[0].d);
        chk("l_ch", m_ch_l, ql[0].ch);
        chk("l_ch_last", m_ch_last_l, ql[0].chl);
        chk("l_last", m_last_l, ql[0].lst);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_s(input int base);
    for (int i = 0; i < NS; i++) fw_s[i] = DS'(base + i);
  endtask

  task automatic start_s(input int base);
    @(negedge clk);
    load_s(base);
    done_s  = 1'b1;
    ready_s = 1'b1;
    @(negedge clk);
    done_s = 1'b0;
  endtask

  task automatic drain_s(input string nm);
    int n = 0;
    ready_s = 1'b1;
    while (qs.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(nm, m_valid_s, 0);
  endtask

  task automatic wait_q_s(input int sz);
    int n = 0;
    while (qs.size() != sz && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s_wait_bound", qs.size(), sz);
  endtask

  task automatic chk_zero_s(input string nm);
    chk({nm, "_valid"}, m_valid_s, 0);
    chk({nm, "_data"}, m_data_s, 0);
    chk({nm, "_ch"}, m_ch_s, 0);
    chk({nm, "_chl"}, m_ch_last_s, 0);
    chk({nm, "_last"}, m_last_s, 0);
    chk({nm, "_busy"}, busy_s, 0);
    chk({nm, "_ovr"}, ovr_s_dut, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got[$];
    bit         pat [4];
    int         n, chl_cnt, last_cnt, vcyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    done_s = 0; ready_s = 0; done_l = 0; ready_l = 0;
    load_s(0);
    for (int i = 0; i < NL; i++) fw_l[i] = '0;
    repeat (2) @(negedge clk);
    chk_zero_s("reset");
    chk("reset_l_valid", m_valid_l, 0);
    rst = 1'b0;

    // 1: single frame, ready held high
    @(negedge clk);
    load_s(8'h10);
    done_s = 1'b1; ready_s = 1'b1;
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      done_s = 1'b0;
      chk("t1_valid", m_valid_s, 1);
      chk("t1_data", m_data_s, 8'h10 + k);
      chk("t1_ch", m_ch_s, (k >= 4) ? 1 : 0);
      chk("t1_ch_last", m_ch_last_s, (k == 3 || k == 7) ? 1 : 0);
      chk("t1_last", m_last_s, (k == 7) ? 1 : 0);
    end
    @(negedge clk);
    chk("t1_busy_end", busy_s, 0);

    // 2: backpressure 1,0,0,1,...
    @(negedge clk);
    load_s(8'h10);
    done_s = 1'b1; ready_s = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      done_s  = 1'b0;
      ready_s = pat[n % 4];
      if (m_valid_s && ready_s) got.push_back(m_data_s);
      n++;
    end while (qs.size() > 0 && n < 100);
    chk("t2_count", got.size(), NS);
    for (int i = 0; i < NS && i < got.size(); i++) chk("t2_word", got[i], 8'h10 + i);
    drain_s("t2_idle");

    // 3: coincident next frame on the final handshake
    start_s(8'h10);
    wait_q_s(1);
    load_s(8'h20);
    done_s = 1'b1;
    @(negedge clk);
    done_s = 1'b0;
    chk("t3_valid", m_valid_s, 1);
    chk("t3_data", m_data_s, 8'h20);
    chk("t3_ovr", ovr_s_dut, 0);
    drain_s("t3_idle");

    // 4: overrun while streaming word 2
    start_s(8'h10);
    wait_q_s(NS - 2);
    load_s(8'h30);
    done_s = 1'b1;
    @(negedge clk);
    done_s = 1'b0;
    chk("t4_ovr", ovr_s_dut, 1);
    chk("t4_data", m_data_s, 8'h13);
    drain_s("t4_idle");
    chk("t4_ovr_sticky", ovr_s_dut, 1);
    start_s(8'h40);
    chk("t4_next_data", m_data_s, 8'h40);
    drain_s("t4_next_idle");

    // 5: asynchronous reset mid-frame while stalled
    start_s(8'h50);
    wait_q_s(3);
    ready_s = 1'b0;
    @(negedge clk);
    chk("t5_hold", m_data_s, 8'h55);
    #2 rst = 1'b1;
    #1 chk_zero_s("t5_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle_valid", m_valid_s, 0);
    chk("t5_idle_ovr", ovr_s_dut, 0);
    start_s(8'h60);
    chk("t5_restart_data", m_data_s, 8'h60);
    chk("t5_restart_ch", m_ch_s, 0);
    drain_s("t5_end");

    // 6: default size, random frame and random ready, one overrun pulse
    @(negedge clk);
    for (int i = 0; i < NL; i++) fw_l[i] = $urandom;
    done_l = 1'b1;
    ready_l = 1'b0;
    n = 0; chl_cnt = 0; last_cnt = 0;
    do begin
      @(negedge clk);
      done_l = (n == 500);
      ready_l = 1'($urandom_range(0, 1));
      if (m_valid_l && ready_l) begin
        if (m_ch_last_l) chl_cnt++;
        if (m_last_l) last_cnt++;
      end
      n++;
    end while (ql.size() > 0 && n < 20000);
    done_l = 1'b0;
    chk("t6_ch_last_count", chl_cnt, 16);
    chk("t6_last_count", last_cnt, 1);
    @(negedge clk);
    chk("t6_ovr", ovr_l_dut, 1);
    chk("t6_idle", m_valid_l, 0);

    // 6b: full throughput, exactly N valid cycles
    for (int i = 0; i < NL; i++) fw_l[i] = $urandom;
    done_l = 1'b1; ready_l = 1'b1;
    vcyc = 0; n = 0;
    do begin
      @(negedge clk);
      done_l = 1'b0;
      if (m_valid_l) vcyc++;
      n++;
    end while (ql.size() > 0 && n < 5000);
    @(negedge clk);
    chk("t6_cycles", vcyc, NL);
    chk("t6b_idle", m_valid_l, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_output_streamer.md
# conv_output_streamer

Read-side companion to the multi-filter convolution layer. When the convolution layer signals a finished frame, this block snapshots the layer's flat output vector (K feature maps of OH×OW words). It then streams the snapshot one word per cycle over a valid/ready interface to downstream logic: pooling, the next layer's loader, or a host DMA. Channel and frame boundary markers are provided with each word.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per output element
- K, 16, number of feature maps (filters) per frame
- OH, 10, feature-map height (H-F+1)
- OW, 10, feature-map width (W-F+1)
- Derived: N = K*OH*OW words per frame; P = OH*OW words per map

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- conv_done  in  1  one-cycle pulse; conv_data holds a complete frame in this cycle
- conv_data  in  [0:N*DATA_WIDTH-1]  flat frame; word i = conv_data[i*DATA_WIDTH +: DATA_WIDTH]; word 0 is MSB-side
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts the word
- m_data  out  DATA_WIDTH  current word
- m_ch  out  clog2(K)  feature-map index of the current word
- m_ch_last  out  1  current word is the last of its map (pixel index P-1)
- m_last  out  1  current word is word N-1 of the frame
- busy  out  1  frame held or streaming (state STREAM)
- overrun  out  1  sticky; set when conv_done arrives while a frame cannot be accepted

## Operation
- States: IDLE, STREAM.
- IDLE:
  - On conv_done, latch conv_data into the frame buffer.
  - Clear word index w, map index c and pixel index p.
  - Go to STREAM.
- STREAM:
  - m_valid=1; m_data = buffer word w; m_ch = c.
  - m_ch_last = (p==P-1); m_last = (w==N-1).
- Handshake is m_valid & m_ready:
  - On handshake, w increments.
  - p increments and wraps to 0 at P-1; c increments when p wraps.
  - On handshake with w==N-1, return to IDLE.
- m_data, m_ch, m_ch_last and m_last stay stable while m_valid=1 and m_ready=0. m_valid never drops without a handshake.
- conv_done in STREAM:
  - If it coincides with the final handshake (w==N-1, m_ready=1), the new frame is latched and the block stays in STREAM with w=c=p=0. No gap cycle, no overrun.
  - Otherwise the frame is dropped, the buffer is unchanged and overrun is set. Overrun clears only on reset.
- Words are passed unmodified. The block performs no arithmetic on the data.
- Reset (any time, including mid-frame): state IDLE; w, c, p, buffer, m_valid, m_data, m_ch, m_ch_last, m_last, busy and overrun all 0. A partial frame is discarded.

## Timing
- Latency: conv_done sampled at edge t gives m_valid=1 with word 0 after edge t (first cycle t+1).
- Throughput: 1 word/cycle with m_ready held high, so a frame takes exactly N cycles.
- Back-to-back frames are gapless only via the coincident-conv_done rule.
- All outputs are registered or decoded directly from registered state. No combinational path from m_ready to m_valid or m_data.
- m_ready is ignored while m_valid=0.

## Structure
- Shared package holds:
  - DATA_WIDTH default
  - clog2 function
  - state encoding (IDLE=0, STREAM=1)
  - N/P derivation helpers, also used by the convolution layer and its loader
- One natural sub-module: conv_stream_index. It holds the w/p/c counters with wrap and last flags, with ports inc, clr, w, c, ch_last, last.
- Frame buffer and read mux stay in the top module.

## Test plan
Use K=2, OH=OW=2, DATA_WIDTH=8 (N=8) unless noted.
1. Single frame: frame words 0x10..0x17, pulse conv_done, m_ready=1.
   - m_valid high on cycles 1..8 with data 0x10..0x17.
   - m_ch = 0,0,0,0,1,1,1,1.
   - m_ch_last on words 3 and 7; m_last on word 7 only; busy falls after cycle 8.
2. Backpressure: same frame, m_ready toggled 1,0,0,1,…
   - Each word is held stable while stalled; the exact sequence 0x10..0x17 is delivered with no loss or duplication.
3. Coincident next frame: conv_done with new data 0x20..0x27 on the cycle of word 7's handshake.
   - Word 0x20 is presented on the very next cycle; overrun stays 0.
4. Overrun: conv_done with 0x30..0x37 while streaming word 2.
   - overrun=1 from the next cycle; the remaining words stay 0x13..0x17.
   - overrun persists afterwards, and the next frame in IDLE is accepted normally.
5. Reset mid-frame: assert reset at word 5 with m_ready=0.
   - All outputs are 0 immediately (asynchronous).
   - After release the block is IDLE, and a new conv_done streams from word 0.
6. Defaults (K=16, OH=OW=10, N=1600): random frame, random m_ready.
   - All 1600 words match the scoreboard; m_ch_last fires every 100 words; m_last fires once.
